uart_comm: RTL and testbench

Host-side serial endpoint for the scope digital core. Receives UART bytes on `RX`, assembles each group of three into a 24-bit command, and presents it on `cmd`/`cmd_rdy` until the core clears it. Transmits single response bytes from the core on `TX` and reports completion on `resp_sent`. Sits between the board RX/TX pins and `dig_core`.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx.sv | 114 +++++++++++
 rtl/uart_comm.sv | 195 +++++++++++++++++++
 tb/tb_uart_comm.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and frame constants for the host-side UART endpoint.
package uart_pkg;

  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle byte strobe.
//   state    | meaning
//   RX_IDLE  | line idle, waiting for a synchronized falling edge
//   RX_START | counting to mid start bit; high sample means glitch
//   RX_DATA  | sampling 8 data bits, LSB first
//   RX_STOP  | sampling stop bit; low means framing error, byte dropped
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] rx_byte_o,
  output logic       byte_rdy_o,
  output logic       rx_idle_o
);

  localparam int               CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
  // Two cycles of the half-bit wait are already spent in edge detection.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 2);
  localparam logic [3:0]       IDX_LAST = 4'(FRAME_BITS - 2);
  localparam logic [3:0]       IDX_STOP = 4'(FRAME_BITS - 1);

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_rdy_q, byte_rdy_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    byte_rdy_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = RX_START;
          cnt_d   = CNT_HALF;
          idx_d   = 4'd0;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (rx_sync_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            cnt_d   = CNT_FULL;
            idx_d   = 4'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = CNT_FULL;
          if (idx_q == IDX_LAST) begin
            state_d = RX_STOP;
            idx_d   = IDX_STOP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          byte_rdy_d = rx_sync_q;
          state_d    = RX_IDLE;
          idx_d      = 4'd0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      idx_q      <= 4'd0;
      shift_q    <= 8'h00;
      byte_rdy_q <= 1'b0;
    end else begin
      rx_meta_q  <= rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      byte_rdy_q <= byte_rdy_d;
    end
  end

  assign rx_byte_o  = shift_q;
  assign byte_rdy_o = byte_rdy_q;
  assign rx_idle_o  = (state_q == RX_IDLE);

endmodule

// File: rtl/uart_comm.sv
// Host-side UART endpoint: 3-byte command assembly with idle timeout, single-byte response TX.
//   state    | meaning
//   TX_IDLE  | line high, accepting send_resp
//   TX_START | driving start bit
//   TX_DATA  | shifting out 8 data bits, LSB first
//   TX_STOP  | driving stop bit; resp_sent pulses as it ends
module uart_comm
  import uart_pkg::*;
#(
  parameter int BAUD_DIV     = 868,
  parameter int TIMEOUT_BITS = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int               CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       IDX_LAST = 4'(FRAME_BITS - 2);
  localparam logic [3:0]       IDX_STOP = 4'(FRAME_BITS - 1);
  localparam int               TMO_CYC  = TIMEOUT_BITS * BAUD_DIV;
  localparam int               TMO_W    = $clog2(TMO_CYC);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYC - 1);

  logic [7:0] rx_byte;
  logic       byte_rdy;
  logic       rx_idle;

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (RX),
    .rx_byte_o  (rx_byte),
    .byte_rdy_o (byte_rdy),
    .rx_idle_o  (rx_idle)
  );

  // Command assembly and partial-command timeout
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]       high_q, high_d, mid_q, mid_d;
  logic [23:0]      cmd_q, cmd_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    high_d     = high_q;
    mid_d      = mid_q;
    cmd_d      = cmd_q;
    cmd_rdy_d  = clr_cmd_rdy ? 1'b0 : cmd_rdy_q;
    tmo_d      = tmo_q;
    if (byte_rdy) begin
      case (byte_cnt_q)
        2'd0: begin
          high_d     = rx_byte;
          byte_cnt_d = 2'd1;
        end
        2'd1: begin
          mid_d      = rx_byte;
          byte_cnt_d = 2'd2;
        end
        default: begin
          byte_cnt_d = 2'd0;
          // A command held unread is never overwritten, unless it is being cleared right now.
          if (!cmd_rdy_q || clr_cmd_rdy) begin
            cmd_d     = {high_q, mid_q, rx_byte};
            cmd_rdy_d = 1'b1;
          end
        end
      endcase
    end else if (byte_cnt_q != 2'd0 && rx_idle && tmo_q == '0) begin
      byte_cnt_d = 2'd0;
    end
    if (byte_cnt_q == 2'd0 || !rx_idle) begin
      tmo_d = TMO_LOAD;
    end else if (tmo_q != '0) begin
      tmo_d = tmo_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= 2'd0;
      high_q     <= 8'h00;
      mid_q      <= 8'h00;
      cmd_q      <= 24'h000000;
      cmd_rdy_q  <= 1'b0;
      tmo_q      <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      high_q     <= high_d;
      mid_q      <= mid_d;
      cmd_q      <= cmd_d;
      cmd_rdy_q  <= cmd_rdy_d;
      tmo_q      <= tmo_d;
    end
  end

  // Transmitter
  tx_state_t        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_q, tx_d;
  logic             resp_sent_q, resp_sent_d;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_idx_d    = tx_idx_q;
    tx_shift_d  = tx_shift_q;
    tx_d        = tx_q;
    resp_sent_d = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (send_resp) begin
          tx_state_d = TX_START;
          tx_shift_d = resp_data;
          tx_cnt_d   = CNT_FULL;
          tx_idx_d   = 4'd0;
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_DATA;
          tx_d       = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_cnt_d   = CNT_FULL;
          tx_idx_d   = 4'd1;
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = CNT_FULL;
          if (tx_idx_q == IDX_LAST) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
            tx_idx_d   = IDX_STOP;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_idx_d   = tx_idx_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) begin
          tx_state_d  = TX_IDLE;
          tx_idx_d    = 4'd0;
          resp_sent_d = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= 4'd0;
      tx_shift_q  <= 8'h00;
      tx_q        <= 1'b1;
      resp_sent_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  assign TX        = tx_q;
  assign resp_sent = resp_sent_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;

endmodule

// File: tb/tb_uart_comm.sv
// Directed bench for uart_comm at BAUD_DIV=16: command table plus hand-written corner sequences.
module tb_uart_comm;

  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst_n, RX, TX, cmd_rdy, clr_cmd_rdy, send_resp, resp_sent;
  logic [23:0] cmd;
  logic [7:0]  resp_data;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  uart_comm #(.BAUD_DIV(B), .TIMEOUT_BITS(24)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp_data   (resp_data),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent)
  );

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [23:0] exp_cmd;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drives one RX frame starting at a falling clock edge; clr_at pulses clr_cmd_rdy at that cycle offset.
  task automatic drive_rx(input logic [7:0] b, input logic stop_v, input int clr_at, input int ncyc);
    logic [9:0] fr;
    int k;
    fr = {stop_v, b, 1'b0};
    for (int n = 0; n < ncyc; n++) begin
      k = n / B;
      RX = fr[k[3:0]];
      clr_cmd_rdy = (n == clr_at);
      @(negedge clk);
    end
    clr_cmd_rdy = 1'b0;
    if (ncyc >= 10 * B) RX = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive_rx(b, 1'b1, -1, 10 * B);
  endtask

  task automatic clear_rdy();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    logic [9:0] txf;
    logic       exp_tx;
    int         k;

    vecs[0] = '{8'h12, 8'h34, 8'h56, 24'h123456};
    vecs[1] = '{8'hFF, 8'h00, 8'hA5, 24'hFF00A5};
    vecs[2] = '{8'h80, 8'h00, 8'h01, 24'h800001};
    vecs[3] = '{8'h7E, 8'h81, 8'h7E, 24'h7E817E};

    rst_n = 1'b0; RX = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", TX, 1);
    check("rst_cmd", cmd, 0);
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_resp_sent", resp_sent, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      send_byte(vecs[i].b0);
      send_byte(vecs[i].b1);
      send_byte(vecs[i].b2);
      check("vec_cmd", cmd, vecs[i].exp_cmd);
      check("vec_rdy", cmd_rdy, 1);
      clr_cmd_rdy = 1'b1;
      check("rdy_before_clr_edge", cmd_rdy, 1);
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      check("rdy_after_clr", cmd_rdy, 0);
    end

    // Response frame timing, ignored mid-frame request, and back-to-back request in the resp_sent cycle
    txf = {1'b1, 8'hA5, 1'b0};
    resp_data = 8'hA5;
    send_resp = 1'b1;
    for (int n = 1; n <= 185; n++) begin
      @(negedge clk);
      if (n == 1 || n == 51 || n == 162) send_resp = 1'b0;
      if (n <= 160) begin
        k = (n - 1) / B;
        exp_tx = txf[k[3:0]];
      end else if (n == 161) begin
        exp_tx = 1'b1;
      end else begin
        exp_tx = (n - 162 < B) ? 1'b0 : 1'b1;
      end
      check("tx_bit", TX, exp_tx);
      check("resp_sent", resp_sent, (n == 161));
      if (n == 50) begin
        send_resp = 1'b1;
        resp_data = 8'h00;
      end
      if (n == 161) begin
        send_resp = 1'b1;
        resp_data = 8'hFF;
      end
    end
    repeat (10 * B) @(negedge clk);

    // Overrun keeps the held command; completion coincident with clear loads the new one
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    check("ovr_first_cmd", cmd, 24'h123456);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    check("ovr_cmd_held", cmd, 24'h123456);
    check("ovr_rdy_held", cmd_rdy, 1);
    send_byte(8'h01); send_byte(8'h02);
    drive_rx(8'h03, 1'b1, 2 + B / 2 + 9 * B, 10 * B);
    check("setwin_cmd", cmd, 24'h010203);
    check("setwin_rdy", cmd_rdy, 1);
    clear_rdy();

    // Partial command discarded after idle timeout
    send_byte(8'h11);
    repeat (25 * B) @(negedge clk);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("tmo_cmd", cmd, 24'h223344);
    check("tmo_rdy", cmd_rdy, 1);
    clear_rdy();

    // Glitch and framing error between bytes must not disturb the count
    send_byte(8'h55);
    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    repeat (30) @(negedge clk);
    drive_rx(8'h99, 1'b0, -1, 10 * B);
    repeat (20) @(negedge clk);
    send_byte(8'h66); send_byte(8'h77);
    check("glitch_fe_cmd", cmd, 24'h556677);
    check("glitch_fe_rdy", cmd_rdy, 1);

    // Reset during a TX data bit and the second RX byte
    send_byte(8'hDE);
    resp_data = 8'h3C;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    drive_rx(8'hAD, 1'b1, -1, 40);
    check("tx_before_rst", TX, 0);
    rst_n = 1'b0;
    #1;
    check("tx_async_rst", TX, 1);
    check("cmd_async_rst", cmd, 0);
    check("rdy_async_rst", cmd_rdy, 0);
    @(negedge clk);
    RX = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("tx_idle_after_rst", TX, 1);
    send_byte(8'hC0); send_byte(8'hFF); send_byte(8'hEE);
    check("post_rst_cmd", cmd, 24'hC0FFEE);
    check("post_rst_rdy", cmd_rdy, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
